// File: rtl/ram_port_arbiter_if.sv
// Per-master RAM access port: request/write bundle in, grant and read return out.
// Arbiter takes the slave side, each requester drives the master side.
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  lock;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters.
// Define ARB_LOCK_EN to let a master hold the grant for bursts of up to LOCK_MAX.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_arbiter_if.slave     m0,
  ram_port_arbiter_if.slave     m1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_write_req,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  logic                  prio;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  rv0;
  logic                  rv1;
  logic                  win;
  logic                  any;
  logic                  rr_win;

  // With a single requester it wins; under contention the favoured one wins.
  assign rr_win = (m0.req & m1.req) ? prio : m1.req;
  assign any    = ~rst & (m0.req | m1.req);

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic          owner_valid;
  logic          owner;
  logic [CW-1:0] lock_cnt;
  logic          own_req;
  logic          own_lock;
  logic          oth_req;
  logic          hold;
  logic          win_lock;

  assign own_req  = owner ? m1.req  : m0.req;
  assign own_lock = owner ? m1.lock : m0.lock;
  assign oth_req  = owner ? m0.req  : m1.req;
  assign hold     = owner_valid & own_req & own_lock &
                    ((lock_cnt < CW'(LOCK_MAX)) | ~oth_req);
  assign win      = hold ? owner : rr_win;
  assign win_lock = win ? m1.lock : m0.lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_valid <= 1'b0;
      owner       <= 1'b0;
      lock_cnt    <= '0;
    end else if (any & win_lock) begin
      owner_valid <= 1'b1;
      owner       <= win;
      if (!hold)
        lock_cnt <= CW'(1);
      else if (lock_cnt != CW'(LOCK_MAX))
        lock_cnt <= lock_cnt + CW'(1);
    end else begin
      owner_valid <= 1'b0;
      lock_cnt    <= '0;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = m0.lock ^ m1.lock;
  assign win         = rr_win;
`endif

  always_comb begin
    m0.gnt         = any & ~win;
    m1.gnt         = any & win;
    ram_addr       = rst ? '0 : last_addr;
    ram_write_req  = 1'b0;
    ram_write_data = '0;
    if (any) begin
      ram_addr       = win ? m1.addr  : m0.addr;
      ram_write_req  = win ? m1.we    : m0.we;
      ram_write_data = win ? m1.wdata : m0.wdata;
    end
  end

  assign m0.rvalid = rv0 & ~rst;
  assign m1.rvalid = rv1 & ~rst;
  assign m0.rdata  = ram_read_data;
  assign m1.rdata  = ram_read_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= 1'b0;
      last_addr <= '0;
      rv0       <= 1'b0;
      rv1       <= 1'b0;
    end else begin
      rv0 <= m0.gnt & ~m0.we;
      rv1 <= m1.gnt & ~m1.we;
      if (any) begin
        prio      <= ~win;
        last_addr <= ram_addr;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter against a rule-level model.
// Compile with ARB_LOCK_EN to also exercise burst locking (LOCK_MAX=4).
module tb_ram_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ram_addr;
  logic          ram_write_req;
  logic [DW-1:0] ram_write_data;
  logic [DW-1:0] ram_read_data;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

  ram_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LOCK_MAX  (LM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m0            (m0_if),
    .m1            (m1_if),
    .ram_addr      (ram_addr),
    .ram_write_req (ram_write_req),
    .ram_write_data(ram_write_data),
    .ram_read_data (ram_read_data)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // write-first RAM with one-cycle read latency
  logic [DW-1:0] mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (ram_write_req) begin
      mem[ram_addr] = ram_write_data;
      ram_read_data <= ram_write_data;
    end else begin
      ram_read_data <= mem.exists(ram_addr) ?
                       mem[ram_addr] : init_val(ram_addr);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // reference model state
  int            fav = 0;
  logic [AW-1:0] m_last = '0;
  logic [DW-1:0] shadow [logic [AW-1:0]];
  bit            erv [2] = '{0, 0};
  logic [DW-1:0] edata = '0;
`ifdef ARB_LOCK_EN
  int owner = -1;
  int run   = 0;
`endif

  // observations from the last tick
  bit            og0, og1, orv0, orv1, owe;
  logic [AW-1:0] oaddr;
  logic [DW-1:0] ord1;

  task automatic drive(input int m, input bit r, input bit we,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit lk);
    if (m == 0) begin
      m0_if.req = r; m0_if.we = we; m0_if.addr = a;
      m0_if.wdata = d; m0_if.lock = lk;
    end else begin
      m1_if.req = r; m1_if.we = we; m1_if.addr = a;
      m1_if.wdata = d; m1_if.lock = lk;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0);
    drive(1, 0, 0, '0, '0, 0);
  endtask

  task automatic tick();
    bit            r  [2];
    bit            wv [2];
    logic [AW-1:0] a  [2];
    logic [DW-1:0] d  [2];
    bit            hold = 0;
    int            w;
    logic [AW-1:0] xa;
    bit            xw;
    logic [DW-1:0] xd;
`ifdef ARB_LOCK_EN
    bit            lk [2];
`endif
    @(negedge clk);
    r[0] = m0_if.req; wv[0] = m0_if.we;
    a[0] = m0_if.addr; d[0] = m0_if.wdata;
    r[1] = m1_if.req; wv[1] = m1_if.we;
    a[1] = m1_if.addr; d[1] = m1_if.wdata;
`ifdef ARB_LOCK_EN
    lk[0] = m0_if.lock; lk[1] = m1_if.lock;
    if (owner >= 0)
      hold = r[owner] && lk[owner] &&
             (run < LM || !r[1-owner]);
`endif
    if (rst) w = -1;
    else if (hold) begin
`ifdef ARB_LOCK_EN
      w = owner;
`else
      w = -1;
`endif
    end
    else if (r[0] && r[1]) w = fav;
    else if (r[0]) w = 0;
    else if (r[1]) w = 1;
    else w = -1;

    if (rst) begin
      xa = '0; xw = 0; xd = '0;
    end else if (w < 0) begin
      xa = m_last; xw = 0; xd = '0;
    end else begin
      xa = a[w]; xw = wv[w]; xd = d[w];
    end

    chk("gnt0", 32'(m0_if.gnt), 32'(w == 0));
    chk("gnt1", 32'(m1_if.gnt), 32'(w == 1));
    chk("ram_addr", 32'(ram_addr), 32'(xa));
    chk("ram_we", 32'(ram_write_req), 32'(xw));
    chk("ram_wdata", 32'(ram_write_data), 32'(xd));
    chk("rvalid0", 32'(m0_if.rvalid), 32'(erv[0] && !rst));
    chk("rvalid1", 32'(m1_if.rvalid), 32'(erv[1] && !rst));
    if (erv[0] && !rst) chk("rdata0", 32'(m0_if.rdata), 32'(edata));
    if (erv[1] && !rst) chk("rdata1", 32'(m1_if.rdata), 32'(edata));

    og0 = m0_if.gnt; og1 = m1_if.gnt;
    orv0 = m0_if.rvalid; orv1 = m1_if.rvalid;
    oaddr = ram_addr; owe = ram_write_req;
    ord1 = m1_if.rdata;

    @(posedge clk);
    erv[0] = 0; erv[1] = 0;
    if (rst) begin
      fav = 0; m_last = '0;
`ifdef ARB_LOCK_EN
      owner = -1; run = 0;
`endif
    end else if (w >= 0) begin
      fav = 1 - w;
      m_last = a[w];
      if (wv[w]) shadow[a[w]] = d[w];
      else begin
        erv[w] = 1;
        edata = shadow.exists(a[w]) ? shadow[a[w]] : init_val(a[w]);
      end
`ifdef ARB_LOCK_EN
      if (lk[w]) begin
        run = (w == owner) ? ((run < LM) ? run + 1 : LM) : 1;
        owner = w;
      end else begin
        owner = -1; run = 0;
      end
    end else begin
      owner = -1; run = 0;
`endif
    end
    #1;
  endtask

  bit pend [2];

  initial begin
    rst = 1;
    drive(0, 1, 1, 16'h1234, 16'h1111, 0);
    drive(1, 1, 0, 16'h0077, 16'h0000, 0);
    tick();
    chk("rst_gnt0", 32'(og0), 32'(0));
    chk("rst_addr", 32'(oaddr), 32'(0));
    tick();
    rst = 0;
    idle();

    // m1 alone streams four reads
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 1, 0, AW'(16'h0010 + i), '0, 0);
      else idle();
      tick();
      if (i < 4) chk("t1_gnt1", 32'(og1), 32'(1));
      if (i > 0) begin
        chk("t1_rv1", 32'(orv1), 32'(1));
        chk("t1_rdata", 32'(ord1), 32'(init_val(AW'(16'h000F + i))));
      end
    end

    // contention straight out of reset alternates m0,m1,...
    rst = 1;
    drive(0, 1, 0, 16'h0020, '0, 0);
    drive(1, 1, 0, 16'h0030, '0, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_gnt0", 32'(og0), 32'(i % 2 == 0));
      chk("t2_addr", 32'(oaddr), (i % 2 == 0) ? 32'h20 : 32'h30);
    end

    // write then read-back through the other master
    idle();
    drive(0, 1, 1, 16'h0004, 16'hBEEF, 0);
    tick();
    idle();
    drive(1, 1, 0, 16'h0004, '0, 0);
    tick();
    chk("t3_gnt1", 32'(og1), 32'(1));
    idle();
    tick();
    chk("t3_rv1", 32'(orv1), 32'(1));
    chk("t3_rdata", 32'(ord1), 32'hBEEF);
    chk("t3_rv0", 32'(orv0), 32'(0));

    // reset lands on a pending read; priority returns to m0
    drive(0, 1, 0, 16'h0040, '0, 0);
    tick();
    idle();
    drive(1, 1, 0, 16'h0041, '0, 0);
    rst = 1;
    tick();
    chk("t4_rv0", 32'(orv0), 32'(0));
    chk("t4_gnt1", 32'(og1), 32'(0));
    rst = 0;
    drive(0, 1, 0, 16'h0042, '0, 0);
    tick();
    chk("t4_gnt0", 32'(og0), 32'(1));
    idle();
    tick();

`ifdef ARB_LOCK_EN
    drive(0, 1, 0, 16'h0060, '0, 0);
    tick();
    drive(1, 1, 0, 16'h0050, '0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_gnt1", 32'(og1), 32'(!(i == 4 || i == 9)));
    end
    idle();
    tick();
`endif

    // idle bus parks on the last address
    drive(0, 1, 1, 16'h00A0, 16'h1357, 0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_addr", 32'(oaddr), 32'h00A0);
      chk("t6_we", 32'(owe), 32'(0));
      chk("t6_rv", 32'({orv0, orv1}), 32'(0));
    end

    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!(pend[m] && $urandom_range(0, 7) != 0))
          drive(m, $urandom_range(0, 2) != 0,
                $urandom_range(0, 1) != 0,
                AW'($urandom_range(0, 15)),
                DW'($urandom),
                $urandom_range(0, 3) != 0);
      end
      tick();
      pend[0] = m0_if.req && !og0;
      pend[1] = m1_if.req && !og1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
